// File: rtl/mux_channel_scanner_pkg.sv
// Shared types and constants for the 4-to-1 mux channel scanner.
package mux_channel_scanner_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        DONE   = 2'd2
    } state_t;

endpackage

// File: rtl/mux_channel_scanner_next_chan_sel.sv
// Priority finder: lowest enabled channel strictly above cur, or the lowest
// enabled channel overall when first is set; none flags an empty search.
module next_chan_sel
    import mux_channel_scanner_pkg::*;
(
    input  logic [NUM_CH-1:0] mask,
    input  logic [SEL_W-1:0]  cur,
    input  logic              first,
    output logic [SEL_W-1:0]  nxt,
    output logic              none
);

    always_comb begin
        nxt  = '0;
        none = 1'b1;
        // Descending walk so the lowest qualifying channel is the last writer.
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (mask[k] && (first || (k > int'(cur)))) begin
                nxt  = SEL_W'(k);
                none = 1'b0;
            end
        end
    end

endmodule

// File: rtl/mux_channel_scanner.sv
// Scans the enabled inputs of a 4-to-1 mux: drives registered selects, waits
// SETTLE_CYCLES per channel, captures mux_out and reports a parallel word.
module mux_channel_scanner
    import mux_channel_scanner_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_W         = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [NUM_CH-1:0] chan_mask,
    input  logic              mux_out,
    output logic              s0,
    output logic              s1,
    output logic              busy,
    output logic              done,
    output logic [NUM_CH-1:0] sample
);

    state_t             state_q, state_n;
    logic [CNT_W-1:0]   cnt_q, cnt_n;
    logic [NUM_CH-1:0]  mask_q, mask_n;
    logic [NUM_CH-1:0]  sample_q, sample_n;
    logic [SEL_W-1:0]   sel_q, sel_n;

    logic [NUM_CH-1:0]  find_mask;
    logic               find_first;
    logic [SEL_W-1:0]   find_nxt;
    logic               find_none;
    logic               last_tick;

    // In IDLE the finder looks at the live mask for the first channel;
    // while settling it walks the latched copy upward.
    assign find_first = (state_q == IDLE);
    assign find_mask  = find_first ? chan_mask : mask_q;
    assign last_tick  = (cnt_q == CNT_W'(SETTLE_CYCLES - 1));

    next_chan_sel u_next_chan_sel (
        .mask  (find_mask),
        .cur   (sel_q),
        .first (find_first),
        .nxt   (find_nxt),
        .none  (find_none)
    );

    always_comb begin
        state_n  = state_q;
        cnt_n    = cnt_q;
        mask_n   = mask_q;
        sel_n    = sel_q;
        sample_n = sample_q;
        case (state_q)
            IDLE: begin
                sel_n = '0;
                if (start) begin
                    sample_n = '0;
                    if (chan_mask != '0) begin
                        mask_n  = chan_mask;
                        sel_n   = find_nxt;
                        cnt_n   = '0;
                        state_n = SETTLE;
                    end else begin
                        state_n = DONE;
                    end
                end
            end
            SETTLE: begin
                cnt_n = cnt_q + CNT_W'(1);
                if (last_tick) begin
                    sample_n[sel_q] = mux_out;
                    if (!find_none) begin
                        sel_n = find_nxt;
                        cnt_n = '0;
                    end else begin
                        sel_n   = '0;
                        state_n = DONE;
                    end
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            mask_q   <= '0;
            sel_q    <= '0;
            sample_q <= '0;
        end else begin
            state_q  <= state_n;
            cnt_q    <= cnt_n;
            mask_q   <= mask_n;
            sel_q    <= sel_n;
            sample_q <= sample_n;
        end
    end

    assign s0     = sel_q[0];
    assign s1     = sel_q[1];
    assign busy   = (state_q != IDLE);
    assign done   = (state_q == DONE);
    assign sample = sample_q;

endmodule

// File: doc/mux_channel_scanner.md
Name: mux_channel_scanner

Overview:
- Sequencer directly upstream/downstream of the 4-to-1 mux: drives the mux select lines s1:s0, waits a programmable settle time, samples the mux output, and assembles the four sampled channels into a parallel word.
- One scan runs per start request, with a per-channel enable mask.
- Completion is signalled with a single-cycle done pulse.
- Replaces manual select sequencing in the mux test harness and in the datapath capture stage.

Parameters:
- SETTLE_CYCLES, 2, cycles each channel's select is held before its sample is taken; legal range 1..15.
- CNT_W, 4, settle-counter width; must satisfy 2^CNT_W > SETTLE_CYCLES.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  scan request; sampled only in IDLE.
- chan_mask  input  4  channel enable, bit k = channel k; latched when start is accepted.
- mux_out  input  1  output of the 4-to-1 mux being scanned.
- s0  output  1  select LSB to the mux.
- s1  output  1  select MSB to the mux.
- busy  output  1  high in SETTLE and DONE.
- done  output  1  one-cycle completion pulse.
- sample  output  4  bit k = value captured from channel k; disabled channels read 0.

Behaviour:
- Reset (async assert, applied immediately regardless of clock; sync release):
  - state=IDLE, s1:s0=00, busy=0, done=0, sample=0000, counter=0, latched mask=0000.
- States: IDLE, SETTLE, DONE.
- IDLE:
  - select held at 00.
  - start=1 and chan_mask!=0: latch mask, clear sample to 0000, set select to the lowest enabled channel, counter=0, go to SETTLE.
  - start=1 and chan_mask==0: clear sample, go directly to DONE.
- SETTLE:
  - Counter increments each cycle.
  - On the edge where counter==SETTLE_CYCLES-1, sample[current channel] <= mux_out.
  - On that same edge: if a higher enabled channel remains, select moves to the next enabled channel (ascending order, disabled channels skipped) and counter=0.
  - Otherwise go to DONE, with select returning to 00.
- DONE: done=1 for exactly one cycle, then unconditionally go to IDLE.
- Latency:
  - Each enabled channel occupies exactly SETTLE_CYCLES cycles.
  - Taking the start-accept edge as edge 0, done is high in the cycle following edge N*SETTLE_CYCLES, where N = number of set mask bits.
  - Next start is accepted no earlier than the edge after done falls; minimum inter-scan gap is 1 IDLE cycle.
- Select outputs are registered (no glitches); s1:s0 always equals the index of the channel being settled.
- sample updates only at capture edges or at start-accept (clear). It is stable and valid from done onwards and holds until the next accepted start.
- start while busy: ignored, with no effect on state, mask or sample. start held high continuously re-triggers a new scan each time IDLE is reached.
- chan_mask changes during a scan: ignored; the latched copy is used.
- mux_out is sampled only at capture edges; all other values are don't-care.
- Reset mid-scan: immediate return to reset values; no done pulse; partial sample is discarded (cleared).

Decomposition:
- Shared package holds:
  - state encoding constants (IDLE=2'd0, SETTLE=2'd1, DONE=2'd2);
  - channel count constant NUM_CH=4;
  - select width SEL_W=2.
- One natural sub-module, next_chan_sel: combinational priority finder. Given the latched mask and the current channel, it returns the next enabled channel index above the current one plus a "none left" flag. It is reused for the first-channel search by presenting current = -1 (first-search mode).
- Counter and FSM stay in the top module.

Test Plan:
- Full scan, SETTLE_CYCLES=2, mask=1111, i0..i3=1,0,1,1:
  - s1:s0 sequence 00,00,01,01,10,10,11,11 over cycles 1..8;
  - done in cycle 9; sample=1101 (bit3..bit0).
- Sparse mask=1010, i1=1, i3=1:
  - select visits only 01 then 11; done 4 cycles after start edge +1;
  - sample=1010; channels 0 and 2 read 0.
- Zero mask:
  - start with chan_mask=0000 gives done in the next cycle, sample=0000, select stays 00.
- Busy and mask changes:
  - start pulses and chan_mask toggles during SETTLE leave the sequence and result unchanged;
  - start held high gives back-to-back scans with exactly one IDLE cycle between done and the next SETTLE.
- Async reset:
  - assert rst_n=0 mid-cycle during channel 2 settle;
  - outputs go to 0 immediately, without waiting for a clock edge;
  - after release, no done pulse appears until a new start is given.
- Settle boundary, SETTLE_CYCLES=1, mask=1111:
  - select changes every cycle; done in cycle 5;
  - mux_out toggled between capture edges does not affect sample.
